// File: rtl/booth_mult_seq_pkg.sv
// rtl/booth_mult_seq_pkg.sv - shared types and defaults for the sequential Booth multiplier
// Package mult_pkg: default operand width, FSM state encoding, Booth recoding codes.
package mult_pkg;

    localparam int N_DEF = 8;

    // Encoding matches what the downstream register bank stores.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    // {Q[0], Q_1} pair examined on each Booth step.
    typedef enum logic [1:0] {
        NOP0 = 2'b00,
        ADD  = 2'b01,
        SUB  = 2'b10,
        NOP1 = 2'b11
    } booth_code_t;

endpackage

// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - operand/result bundle between a requester and booth_mult_seq
// Signals: start, A, B (requester to multiplier); resultado, done, busy (multiplier to requester).
// Modports: master = requester, slave = multiplier.
interface booth_mult_seq_if #(
    parameter int N = mult_pkg::N_DEF
);
    logic                  start;
    logic signed [N-1:0]   A;
    logic signed [N-1:0]   B;
    logic signed [2*N-1:0] resultado;
    logic                  done;
    logic                  busy;

    modport master (
        output start, A, B,
        input  resultado, done, busy
    );

    modport slave (
        input  start, A, B,
        output resultado, done, busy
    );
endinterface

// File: rtl/booth_mult_seq_step.sv
// rtl/booth_mult_seq_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
// Inputs: acc (N+1, sign-extended accumulator), q, q_1, m (multiplicand).
// Outputs: acc_next, q_next, q_1_next = {acc,q,q_1} after the step.
module booth_step
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N-1:0] m,
    output logic [N:0]   acc_next,
    output logic [N-1:0] q_next,
    output logic         q_1_next
);
    logic [N:0]  m_ext;
    logic [N:0]  sum;
    booth_code_t code;

    // One extra accumulator bit keeps subtracting -2^(N-1) exact.
    assign m_ext = {m[N-1], m};
    assign code  = booth_code_t'({q[0], q_1});

    always_comb begin
        sum = acc;
        case (code)
            ADD:     sum = acc + m_ext;
            SUB:     sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, q, q_1}.
    assign acc_next = {sum[N], sum[N:1]};
    assign q_next   = {sum[0], q[N-1:1]};
    assign q_1_next = q[0];
endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential signed radix-2 Booth multiplier, one step per clock
// Ports: clk; rst (sync, active low); bus (slave: start, A, B in; resultado, done, busy out).
// Optional macro BOOTH_DEBUG_PORTS_EN adds estado_actual, temp, contador outputs.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_mult_seq_if.slave      bus
`ifdef BOOTH_DEBUG_PORTS_EN
    ,
    output logic                 estado_actual,
    output logic [1:0]           temp,
    output logic [$clog2(N)-1:0] contador
`endif
);
    localparam int CW = $clog2(N);

    estado_t        estado, estado_n;
    logic [N:0]     acc, acc_n;
    logic [N-1:0]   q, q_n;
    logic           q_1, q_1_n;
    logic [N-1:0]   m, m_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2*N-1:0] res, res_n;
    logic           done_r, done_n;

    logic [N:0]     acc_s;
    logic [N-1:0]   q_s;
    logic           q_1_s;

    booth_step #(.N(N)) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_s),
        .q_next   (q_s),
        .q_1_next (q_1_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado <= IDLE;
            acc    <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            m      <= '0;
            cnt    <= '0;
            res    <= '0;
            done_r <= 1'b0;
        end else begin
            estado <= estado_n;
            acc    <= acc_n;
            q      <= q_n;
            q_1    <= q_1_n;
            m      <= m_n;
            cnt    <= cnt_n;
            res    <= res_n;
            done_r <= done_n;
        end
    end

    always_comb begin
        estado_n = estado;
        acc_n    = acc;
        q_n      = q;
        q_1_n    = q_1;
        m_n      = m;
        cnt_n    = cnt;
        res_n    = res;
        done_n   = done_r;
        case (estado)
            IDLE: begin
                if (bus.start) begin
                    m_n      = bus.A;
                    q_n      = bus.B;
                    acc_n    = '0;
                    q_1_n    = 1'b0;
                    cnt_n    = '0;
                    done_n   = 1'b0;
                    estado_n = RUN;
                end
            end
            RUN: begin
                acc_n = acc_s;
                q_n   = q_s;
                q_1_n = q_1_s;
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(N - 1)) begin
                    // Product is the low N bits of Acc (its top bit only guards the add) and Q.
                    estado_n = IDLE;
                    done_n   = 1'b1;
                    res_n    = {acc_s[N-1:0], q_s};
                    cnt_n    = '0;
                end
            end
            default: estado_n = IDLE;
        endcase
    end

    assign bus.resultado = res;
    assign bus.done      = done_r;
    assign bus.busy      = (estado == RUN);

`ifdef BOOTH_DEBUG_PORTS_EN
    // Straight taps of registers, so they change on the same edges as the state itself.
    assign estado_actual = estado;
    assign temp          = {q[0], q_1};
    assign contador      = cnt;
`endif
endmodule
